store_unit: RTL and testbench

Store-side memory interface for the core: the write-direction counterpart of the load extractor. It accepts one store per request (SB/SH/SW selected by funct3), byte-aligns the register data into 32-bit memory lanes, generates byte strobes, and drives the data-memory write port through a valid/ready handshake. Stores that cross a word boundary are split into two word-aligned beats. Illegal funct3 values are reported as a fault without touching memory.

---
 rtl/store_unit_pkg.sv | 32 +++
 rtl/store_unit_if.sv | 26 ++
 rtl/store_lane_align.sv | 30 +++
 rtl/store_unit.sv | 144 ++++++++++++++
 tb/tb_store_unit.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/store_unit_pkg.sv
// Shared definitions for the store unit: funct3 encodings, FSM state
// encoding and the per-size byte-strobe helper.
package store_unit_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BEAT0 = 2'b01,
        ST_BEAT1 = 2'b10,
        ST_FAULT = 2'b11
    } state_e;

    // Unshifted byte-enable pattern for a store size; zero marks an illegal funct3.
    function automatic logic [3:0] base_mask(input logic [2:0] f3);
        logic [3:0] m;
        case (f3)
            F3_SB:   m = 4'b0001;
            F3_SH:   m = 4'b0011;
            F3_SW:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic f3_legal(input logic [2:0] f3);
        return (base_mask(f3) != 4'b0000);
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Request and memory-write-port bundle for the store unit.
// slave  = the store unit itself; master = the core/memory side driving it.
interface store_unit_if;
    logic        reqValid;
    logic        reqReady;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] dataIn;
    logic        memValid;
    logic        memReady;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memWstrb;
    logic        done;
    logic        fault;

    modport slave (
        input  reqValid, funct3, addr, dataIn, memReady,
        output reqReady, memValid, memAddr, memWdata, memWstrb, done, fault
    );

    modport master (
        output reqValid, funct3, addr, dataIn, memReady,
        input  reqReady, memValid, memAddr, memWdata, memWstrb, done, fault
    );
endinterface

// File: rtl/store_lane_align.sv
// Combinational lane alignment: positions store data and byte strobes
// across a 64-bit window starting at the containing word, so the upper
// half describes the spill-over into the next word.
module store_lane_align
    import store_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] data_i,
    output logic [7:0]  mask8_o,
    output logic [63:0] data64_o,
    output logic        crosses_word_o
);

    logic [31:0] data_masked_s;

    // Trim data to the store width, then shift data and strobes by the byte offset.
    always_comb begin
        case (funct3_i)
            F3_SB:   data_masked_s = {24'h000000, data_i[7:0]};
            F3_SH:   data_masked_s = {16'h0000, data_i[15:0]};
            F3_SW:   data_masked_s = data_i;
            default: data_masked_s = 32'h0000_0000;
        endcase
        mask8_o        = {4'b0000, base_mask(funct3_i)} << off_i;
        data64_o       = {32'h0000_0000, data_masked_s} << {off_i, 3'b000};
        crosses_word_o = (mask8_o[7:4] != 4'b0000);
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts SB/SH/SW requests, issues one or two word-aligned
// write beats over a valid/ready port, and pulses done or fault.
// A FAULT cycle also accepts a new request so a rejected store costs no
// bubble: reqReady is high alongside the fault pulse.
module store_unit
    import store_unit_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    store_unit_if.slave  bus
);

    state_e      state_q, state_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic        need_b1_q, need_b1_d;
    logic [31:0] b1_data_q, b1_data_d;
    logic [3:0]  b1_strb_q, b1_strb_d;

    logic        req_ready_s;
    logic        accept_s;
    logic [7:0]  mask8_s;
    logic [63:0] data64_s;
    logic        crosses_s;

    store_lane_align u_align (
        .funct3_i       (bus.funct3),
        .off_i          (bus.addr[1:0]),
        .data_i         (bus.dataIn),
        .mask8_o        (mask8_s),
        .data64_o       (data64_s),
        .crosses_word_o (crosses_s)
    );

    assign req_ready_s  = ((state_q == ST_IDLE) || (state_q == ST_FAULT)) && rst_n;
    assign accept_s     = bus.reqValid && req_ready_s;

    assign bus.reqReady = req_ready_s;
    assign bus.memValid = mem_valid_q;
    assign bus.memAddr  = mem_addr_q;
    assign bus.memWdata = mem_wdata_q;
    assign bus.memWstrb = mem_wstrb_q;
    assign bus.done     = done_q;
    assign bus.fault    = fault_q;

    // Next-state and next-output logic; beat registers hold until a handshake.
    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        need_b1_d   = need_b1_q;
        b1_data_d   = b1_data_q;
        b1_strb_d   = b1_strb_q;
        case (state_q)
            ST_IDLE, ST_FAULT: begin
                mem_valid_d = 1'b0;
                if (accept_s) begin
                    if (!f3_legal(bus.funct3) || (crosses_s && !SPLIT_MISALIGNED)) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        state_d     = ST_BEAT0;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {bus.addr[31:2], 2'b00};
                        mem_wstrb_d = mask8_s[3:0];
                        mem_wdata_d = data64_s[31:0];
                        need_b1_d   = crosses_s;
                        b1_strb_d   = mask8_s[7:4];
                        b1_data_d   = data64_s[63:32];
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BEAT0: begin
                if (bus.memReady) begin
                    if (need_b1_q) begin
                        state_d     = ST_BEAT1;
                        mem_addr_d  = mem_addr_q + 32'd4;
                        mem_wstrb_d = b1_strb_q;
                        mem_wdata_d = b1_data_q;
                    end else begin
                        state_d     = ST_IDLE;
                        mem_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end
                end else begin
                    state_d = ST_BEAT0;
                end
            end
            ST_BEAT1: begin
                if (bus.memReady) begin
                    state_d     = ST_IDLE;
                    mem_valid_d = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    state_d = ST_BEAT1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    // State, beat and pulse registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_wstrb_q <= 4'b0000;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            need_b1_q   <= 1'b0;
            b1_data_q   <= 32'h0000_0000;
            b1_strb_q   <= 4'b0000;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            need_b1_q   <= need_b1_d;
            b1_data_q   <= b1_data_d;
            b1_strb_q   <= b1_strb_d;
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: one split-enabled instance and one
// split-disabled instance, expected values hand-computed per vector.
module tb_store_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_bad    = 0;

    always #5 clk = ~clk;

    store_unit_if u_if ();
    store_unit_if u_if_ns ();

    store_unit #(.SPLIT_MISALIGNED(1'b1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    store_unit #(.SPLIT_MISALIGNED(1'b0)) u_dut_ns (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if_ns)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] a, input logic [3:0] s,
                            input logic [31:0] d);
        chk({tag, ".valid"}, {63'd0, u_if.memValid}, 64'd1);
        chk({tag, ".addr"},  {32'd0, u_if.memAddr},  {32'd0, a});
        chk({tag, ".strb"},  {60'd0, u_if.memWstrb}, {60'd0, s});
        chk({tag, ".data"},  {32'd0, u_if.memWdata}, {32'd0, d});
    endtask

    // Present a request for one cycle; returns at the negedge of cycle T+1.
    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        u_if.reqValid = 1'b1;
        u_if.funct3   = f3;
        u_if.addr     = a;
        u_if.dataIn   = d;
        @(negedge clk);
        u_if.reqValid = 1'b0;
        u_if.funct3   = 3'b111;
        u_if.addr     = 32'hDEAD_BEEF;
        u_if.dataIn   = 32'hFFFF_FFFF;
    endtask

    initial begin
        rst_n            = 1'b0;
        u_if.reqValid    = 1'b0;
        u_if.funct3      = 3'b000;
        u_if.addr        = 32'h0;
        u_if.dataIn      = 32'h0;
        u_if.memReady    = 1'b1;
        u_if_ns.reqValid = 1'b0;
        u_if_ns.funct3   = 3'b000;
        u_if_ns.addr     = 32'h0;
        u_if_ns.dataIn   = 32'h0;
        u_if_ns.memReady = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst.valid", {63'd0, u_if.memValid}, 64'd0);
        chk("rst.addr",  {32'd0, u_if.memAddr},  64'd0);
        chk("rst.data",  {32'd0, u_if.memWdata}, 64'd0);
        chk("rst.strb",  {60'd0, u_if.memWstrb}, 64'd0);
        chk("rst.done",  {63'd0, u_if.done},     64'd0);
        chk("rst.fault", {63'd0, u_if.fault},    64'd0);
        chk("rst.ready", {63'd0, u_if.reqReady}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel.ready", {63'd0, u_if.reqReady}, 64'd1);
        chk("rel.valid", {63'd0, u_if.memValid}, 64'd0);

        // SB at byte 3
        send(3'b000, 32'h0000_1003, 32'hAABB_CCDD);
        chk_beat("sb", 32'h0000_1000, 4'b1000, 32'hDD00_0000);
        chk("sb.done_early", {63'd0, u_if.done}, 64'd0);
        @(negedge clk);
        chk("sb.done",  {63'd0, u_if.done},     64'd1);
        chk("sb.idle",  {63'd0, u_if.memValid}, 64'd0);
        chk("sb.ready", {63'd0, u_if.reqReady}, 64'd1);
        @(negedge clk);
        chk("sb.done_pulse", {63'd0, u_if.done}, 64'd0);

        // SW crossing a word boundary, split into two beats
        send(3'b010, 32'h0000_2002, 32'h1122_3344);
        chk_beat("sw_b0", 32'h0000_2000, 4'b1100, 32'h3344_0000);
        @(negedge clk);
        chk_beat("sw_b1", 32'h0000_2004, 4'b0011, 32'h0000_1122);
        chk("sw.done_early", {63'd0, u_if.done}, 64'd0);
        @(negedge clk);
        chk("sw.done",  {63'd0, u_if.done},     64'd1);
        chk("sw.valid", {63'd0, u_if.memValid}, 64'd0);
        @(negedge clk);
        chk("sw.done_once", {63'd0, u_if.done}, 64'd0);

        // Same store on the split-disabled instance: fault, no memory access
        u_if_ns.reqValid = 1'b1;
        u_if_ns.funct3   = 3'b010;
        u_if_ns.addr     = 32'h0000_2002;
        u_if_ns.dataIn   = 32'h1122_3344;
        @(negedge clk);
        u_if_ns.reqValid = 1'b0;
        chk("ns.fault", {63'd0, u_if_ns.fault},    64'd1);
        chk("ns.valid", {63'd0, u_if_ns.memValid}, 64'd0);
        chk("ns.done",  {63'd0, u_if_ns.done},     64'd0);
        @(negedge clk);
        chk("ns.fault_pulse", {63'd0, u_if_ns.fault},    64'd0);
        chk("ns.valid2",      {63'd0, u_if_ns.memValid}, 64'd0);

        // SH straddling the top of the address space
        send(3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF);
        chk_beat("sh_b0", 32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000);
        @(negedge clk);
        chk_beat("sh_b1", 32'h0000_0000, 4'b0001, 32'h0000_00BE);
        @(negedge clk);
        chk("sh.done", {63'd0, u_if.done}, 64'd1);

        // Illegal funct3 followed immediately by an aligned SW
        @(negedge clk);
        send(3'b011, 32'h0000_0010, 32'h1234_5678);
        chk("ill.fault", {63'd0, u_if.fault},    64'd1);
        chk("ill.valid", {63'd0, u_if.memValid}, 64'd0);
        chk("ill.ready", {63'd0, u_if.reqReady}, 64'd1);
        chk("ill.done",  {63'd0, u_if.done},     64'd0);
        send(3'b010, 32'h0000_0020, 32'hCAFE_F00D);
        chk("ill.fault_pulse", {63'd0, u_if.fault}, 64'd0);
        chk_beat("b2b", 32'h0000_0020, 4'b1111, 32'hCAFE_F00D);
        @(negedge clk);
        chk("b2b.done", {63'd0, u_if.done}, 64'd1);

        // Back-pressure: five stalled edges, beat held stable
        u_if.memReady = 1'b0;
        send(3'b010, 32'h0000_0000, 32'h5A5A_1234);
        for (int i = 0; i < 5; i++) begin
            chk_beat("stall", 32'h0000_0000, 4'b1111, 32'h5A5A_1234);
            chk("stall.done", {63'd0, u_if.done}, 64'd0);
            @(negedge clk);
        end
        chk_beat("stall_end", 32'h0000_0000, 4'b1111, 32'h5A5A_1234);
        u_if.memReady = 1'b1;
        @(negedge clk);
        chk("stall.done_late", {63'd0, u_if.done},     64'd1);
        chk("stall.valid_off", {63'd0, u_if.memValid}, 64'd0);

        // Reset during beat0 of a split SW abandons the store
        send(3'b010, 32'h0000_3001, 32'h0102_0304);
        chk_beat("ab_b0", 32'h0000_3000, 4'b1110, 32'h0203_0400);
        rst_n = 1'b0;
        @(negedge clk);
        chk("ab.valid", {63'd0, u_if.memValid}, 64'd0);
        chk("ab.done",  {63'd0, u_if.done},     64'd0);
        chk("ab.ready", {63'd0, u_if.reqReady}, 64'd0);
        chk("ab.addr",  {32'd0, u_if.memAddr},  64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ab.valid2", {63'd0, u_if.memValid}, 64'd0);
        chk("ab.done2",  {63'd0, u_if.done},     64'd0);
        chk("ab.ready2", {63'd0, u_if.reqReady}, 64'd1);

        // Fresh SB after release
        send(3'b000, 32'h0000_4001, 32'h0000_00AB);
        chk_beat("post", 32'h0000_4000, 4'b0010, 32'h0000_AB00);
        @(negedge clk);
        chk("post.done", {63'd0, u_if.done}, 64'd1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
